// File: rtl/digit_mult_pkg.sv
// rtl/digit_mult_pkg.sv - shared types and constants for the digit-serial multiplier
package digit_mult_pkg;

    // Digit width in bits; the datapath multiplies one digit of each operand per cycle
    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult2by2.sv
// rtl/mult2by2.sv - combinational digit-by-digit multiplier
module mult2by2
    import digit_mult_pkg::*;
(
    input  logic [DIGIT_W-1:0]   i_x,
    input  logic [DIGIT_W-1:0]   i_y,
    output logic [2*DIGIT_W-1:0] o_p
);

    logic [2*DIGIT_W-1:0] w_x_ext;
    logic [2*DIGIT_W-1:0] w_y_ext;

    assign w_x_ext = {{DIGIT_W{1'b0}}, i_x};
    assign w_y_ext = {{DIGIT_W{1'b0}}, i_y};

    // Full product of two digits always fits in 2*DIGIT_W bits
    assign o_p = w_x_ext * w_y_ext;

endmodule

// File: rtl/digit_serial_mult.sv
// rtl/digit_serial_mult.sv - digit-serial unsigned multiplier; optional DIGIT_SERIAL_MULT_ZERO_SKIP_EN
module digit_serial_mult
    import digit_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    // Number of digits per operand and the index width needed to walk them
    localparam int D     = WIDTH / DIGIT_W;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

    state_t                r_state;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic [2*WIDTH-1:0]    r_acc;
    logic [IDX_W-1:0]      r_i;
    logic [IDX_W-1:0]      r_j;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [2*WIDTH-1:0]    r_product;

    logic [DIGIT_W-1:0]    w_da;
    logic [DIGIT_W-1:0]    w_db;
    logic [2*DIGIT_W-1:0]  w_pp;
    logic [2*WIDTH-1:0]    w_pp_ext;
    logic [IDX_W:0]        w_isum;
    logic [2*WIDTH-1:0]    w_pp_shifted;
    logic [2*WIDTH-1:0]    w_acc_next;
    logic                  w_last;

    // Select digit i of a and digit j of b
    assign w_da = r_a[r_i*DIGIT_W +: DIGIT_W];
    assign w_db = r_b[r_j*DIGIT_W +: DIGIT_W];

    mult2by2 u_mult2by2 (
        .i_x (w_da),
        .i_y (w_db),
        .o_p (w_pp)
    );

    // Partial product weight is 2*(i+j): append one zero bit to i+j since DIGIT_W is 2
    assign w_isum       = {1'b0, r_i} + {1'b0, r_j};
    assign w_pp_ext     = (2*WIDTH)'(w_pp);
    assign w_pp_shifted = w_pp_ext << {w_isum, 1'b0};
    assign w_acc_next   = r_acc + w_pp_shifted;
    assign w_last       = (r_i == LAST_IDX) && (r_j == LAST_IDX);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

    // Control FSM with registered handshake outputs; walks j fastest, then i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_acc      <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
`ifdef DIGIT_SERIAL_MULT_ZERO_SKIP_EN
                        if ((a == '0) || (b == '0)) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_product   <= '0;
                        end else
`endif
                        begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_product   <= w_acc_next;
                    end else if (r_j == LAST_IDX) begin
                        r_j <= '0;
                        r_i <= r_i + IDX_W'(1);
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_mult.sv
// tb/tb_digit_serial_mult.sv - scoreboard bench for digit_serial_mult
module tb_digit_serial_mult;

    localparam int WIDTH    = 8;
    localparam int NDIG     = WIDTH / 2;
    localparam int FULL_LAT = NDIG * NDIG + 1;
`ifdef DIGIT_SERIAL_MULT_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   a         = '0;
    logic [WIDTH-1:0]   b         = '0;
    logic               in_ready;
    logic               out_valid;
    logic               busy;
    logic [2*WIDTH-1:0] product;

    int n_total = 0;
    int n_pass  = 0;
    logic [2*WIDTH-1:0] sb[$];

    digit_serial_mult #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: every accepted product is compared with the oldest expected value
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = sb.pop_front();
                chk("product", longint'(product), longint'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Wait for in_ready, present operands for one handshake and record the model result
    task automatic issue(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk);
        sb.push_back((2*WIDTH)'(xa) * (2*WIDTH)'(xb));
        #1;
        in_valid = 1'b0;
    endtask

    // Issue one operation and follow it to completion, optionally with random back-pressure
    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input bit rnd, output int lat, output int bc);
        bit done;
        issue(xa, xb);
        lat  = 0;
        bc   = 0;
        done = 1'b0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        for (int k = 1; k < 300; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (out_valid && lat == 0) lat = k;
            if (out_valid && out_ready) done = 1'b1;
            @(posedge clk); #1;
            if (done) break;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) chk("result_timeout", 0, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        int lat, bc, ov_cnt;
        logic [2*WIDTH-1:0] held;
        logic [WIDTH-1:0] ra, rb;

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Small operands: latency and busy duration
        run_op(8'h03, 8'h05, 1'b0, lat, bc);
        chk("lat_03x05", lat, FULL_LAT);
        chk("busy_03x05", bc, FULL_LAT - 1);

        // Largest operands
        run_op(8'hFF, 8'hFF, 1'b0, lat, bc);
        chk("busy_FFxFF", bc, NDIG * NDIG);
        chk("lat_FFxFF", lat, FULL_LAT);

        // Zero operand
        run_op(8'h00, 8'h7F, 1'b0, lat, bc);
        chk("lat_00x7F", lat, ZSKIP ? 1 : FULL_LAT);
        chk("busy_00x7F", bc, ZSKIP ? 0 : NDIG * NDIG);

        // Back-pressure: output held stable for 5 cycles
        out_ready = 1'b0;
        issue(8'h5A, 8'hC3);
        lat = 0;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        chk("stall_lat", lat, FULL_LAT);
        held = product;
        chk("stall_value", held, 16'h5A * 16'hC3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_product", product, held);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_back_idle_in_ready", in_ready, 1);
        chk("stall_back_idle_out_valid", out_valid, 0);

        // Operand offered mid-run must be ignored
        issue(8'hA5, 8'h3C);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = 1; break; end
        end
        chk("midrun_done_seen", lat, 1);
        chk("midrun_product", product, 16'h26AC);
        ov_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid && k > 1) ov_cnt++;
        end
        chk("midrun_no_second_result", ov_cnt, 0);
        chk("midrun_idle_in_ready", in_ready, 1);

        // Reset during RUN aborts the operation
        @(posedge clk); #1;
        issue(8'h11, 8'h22);
        ov_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 0);
        chk("abort_no_pulse_before", ov_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_ready_after_release", in_ready, 1);
        run_op(8'h02, 8'h81, 1'b0, lat, bc);
        chk("post_reset_lat", lat, FULL_LAT);

        // Randomized operands with random back-pressure
        for (int t = 0; t < 30; t++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            run_op(ra, rb, 1'b1, lat, bc);
            chk("rand_lat", lat, (ZSKIP && (ra == 0 || rb == 0)) ? 1 : FULL_LAT);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
